llc_rst_flush_seq: RTL and testbench
====================================

# llc_rst_flush_seq

Sequencer for the LLC's whole-cache reset and flush sweeps.
- Walks every set index and issues one tag/state-array write per set.
- Builds the per-way reset/flush write mask: all ways for a reset, valid DATA ways for a flush.
- Reports completion through a valid/ready done handshake.
- Sits between the LLC control FSM and the update stage, which otherwise sees only per-set resume events.

## Interface
Parameters:
- LLC_SETS, 256, number of sets; power of two, ≥2.
- LLC_WAYS, 16, number of ways; also the width of the write mask.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rst_req  in  1  pulse; request a full reset sweep.
- flush_req  in  1  pulse; request a full flush sweep.
- stall  in  1  array port busy; the sequencer holds and issues nothing.
- flush_flags  in  LLC_WAYS  per-way (state==VALID && hprot==DATA), for the set read in the previous cycle.
- busy  out  1  sweep in progress (state != IDLE).
- rd_en  out  1  array read strobe (flush only).
- rd_set  out  $clog2(LLC_SETS)  set index to read.
- wr_set  out  $clog2(LLC_SETS)  set index to write.
- wr_rst_flush  out  LLC_WAYS  per-way invalidate write enables.
- wr_en_evict_way  out  1  also clear the evict-way pointer (reset only).
- done_valid  out  1  sweep finished.
- done_is_flush  out  1  finished sweep was a flush; valid with done_valid.
- done_ready  in  1  consumer accepts done.
- flush_line_cnt  out  32  lines invalidated by flushes (see Configuration).

## Operation
- FSM states: IDLE, RST_WR, FL_RD, FL_WR, DONE. Registers:
  - set_cnt, $clog2(LLC_SETS) bits.
  - kind, 0=reset / 1=flush.
  - flush_pend.
- IDLE:
  - rst_req → RST_WR, set_cnt=0, kind=0.
  - Else flush_req or flush_pend → FL_RD, set_cnt=0, kind=1, flush_pend cleared.
  - Reset wins when rst_req and flush_req arrive together; the flush_req sets flush_pend.
- RST_WR, when !stall:
  - Drive wr_set=set_cnt, wr_rst_flush=all ones, wr_en_evict_way=1.
  - If set_cnt==LLC_SETS-1 → DONE, else set_cnt+1.
- FL_RD, when !stall: rd_en=1, rd_set=set_cnt → FL_WR.
- FL_WR:
  - Sample flush_flags unconditionally on entry; this is the read return, and stall does not delay it. Drive the registered flags while stalled.
  - When !stall: wr_set=set_cnt, wr_rst_flush=flags.
  - If last set → DONE, else set_cnt+1 and → FL_RD.
  - An all-zero mask still spends the FL_WR cycle.
- DONE: done_valid=1, done_is_flush=kind. On done_ready → IDLE.
- rst_req in any non-IDLE state, including DONE before acceptance:
  - Aborts the current sweep and restarts as a reset: RST_WR, set_cnt=0, kind=0.
  - An aborted flush sets flush_pend.
- flush_req while busy sets flush_pend; multiple requests coalesce into one.
- All strobes are 0 while stall=1 and in IDLE/DONE. set_cnt never wraps; the last set exits to DONE.

## Timing
- Reset value of every output is 0; state=IDLE, set_cnt=0, flush_pend=0, counter=0.
- Request seen at edge N → first write (RST_WR) or read (FL_RD) is driven in cycle N+1.
- Reset sweep latency, no stall: LLC_SETS write cycles; done_valid is high the cycle after the last write.
- Flush sweep latency: 2·LLC_SETS cycles plus stall cycles.
- done_valid stays high until the cycle done_ready is sampled high; IDLE next cycle.
- A new request is accepted in IDLE the cycle after the done handshake, or in the same cycle it returns to IDLE when flush_pend is set.
- rst mid-sweep: next cycle IDLE, all outputs 0, flush_pend cleared.

## Configuration
- LLC_SEQ_FLUSH_CNT_EN defined:
  - flush_line_cnt is a 32-bit counter, incremented by popcount(wr_rst_flush) on each FL_WR write.
  - It saturates at 2^32-1, is cleared only by rst, and is never touched by reset sweeps.
- Undefined: flush_line_cnt tied to 0; no counter logic.

## Test plan
All scenarios use LLC_SETS=4, LLC_WAYS=4.
- Reset sweep: rst_req pulse, no stall → wr_set 0,1,2,3 on 4 consecutive cycles, wr_rst_flush=4'hF, wr_en_evict_way=1; then done_valid=1, done_is_flush=0; done_ready=1 → busy=0.
- Flush sweep: flush_flags per read = 4'b0101, 0, 4'hF, 4'b1000 → wr_rst_flush mirrors them, one per 2 cycles. With LLC_SEQ_FLUSH_CNT_EN, flush_line_cnt=7.
- Stall: stall=1 for 3 cycles during FL_WR of set 1 → no strobes for 3 cycles, mask preserved, total latency 8+3 cycles.
- Simultaneous rst_req+flush_req in IDLE → reset sweep first; after done handshake, the flush sweep starts automatically.
- Abort: rst_req during FL_RD of set 2 → next cycle RST_WR with wr_set=0; the flush re-runs after the reset done.
- Done backpressure: done_ready held 0 for 5 cycles → done_valid stays 1, no strobes; rst mid-DONE → all outputs 0 next cycle.

Source files
------------

// File: rtl/llc_rst_flush_seq.sv
// LLC whole-cache reset/flush sweep sequencer: one tag/state write per set, done via valid/ready.
// Optional flushed-line counter enabled by defining LLC_SEQ_FLUSH_CNT_EN.
module llc_rst_flush_seq #(
    parameter int LLC_SETS = 256,
    parameter int LLC_WAYS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rst_req,
    input  logic                        flush_req,
    input  logic                        stall,
    input  logic [LLC_WAYS-1:0]         flush_flags,
    output logic                        busy,
    output logic                        rd_en,
    output logic [$clog2(LLC_SETS)-1:0] rd_set,
    output logic [$clog2(LLC_SETS)-1:0] wr_set,
    output logic [LLC_WAYS-1:0]         wr_rst_flush,
    output logic                        wr_en_evict_way,
    output logic                        done_valid,
    output logic                        done_is_flush,
    input  logic                        done_ready,
    output logic [31:0]                 flush_line_cnt
);
    localparam int SW = $clog2(LLC_SETS);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST_WR = 3'd1;
    localparam logic [2:0] S_FL_RD  = 3'd2;
    localparam logic [2:0] S_FL_WR  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [SW-1:0] LAST_SET = SW'(LLC_SETS - 1);

    logic [2:0]          state_q, state_d;
    logic [SW-1:0]       set_cnt_q, set_cnt_d;
    logic                kind_q, kind_d;
    logic                flush_pend_q, flush_pend_d;
    logic [LLC_WAYS-1:0] flags_q, flags_d;
    logic                fl_first_q, fl_first_d;
    logic [LLC_WAYS-1:0] mask_cur;

    // The array read returns on the first FL_WR cycle; later (stalled) cycles replay the captured copy.
    assign mask_cur = fl_first_q ? flush_flags : flags_q;

    always_comb begin
        state_d         = state_q;
        set_cnt_d       = set_cnt_q;
        kind_d          = kind_q;
        flush_pend_d    = flush_pend_q;
        flags_d         = flags_q;
        fl_first_d      = 1'b0;
        rd_en           = 1'b0;
        rd_set          = '0;
        wr_set          = '0;
        wr_rst_flush    = '0;
        wr_en_evict_way = 1'b0;
        done_valid      = 1'b0;
        done_is_flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rst_req) begin
                    state_d   = S_RST_WR;
                    set_cnt_d = '0;
                    kind_d    = 1'b0;
                    if (flush_req) flush_pend_d = 1'b1;
                end else if (flush_req || flush_pend_q) begin
                    state_d      = S_FL_RD;
                    set_cnt_d    = '0;
                    kind_d       = 1'b1;
                    flush_pend_d = 1'b0;
                end
            end
            S_RST_WR: begin
                if (!stall) begin
                    wr_set          = set_cnt_q;
                    wr_rst_flush    = '1;
                    wr_en_evict_way = 1'b1;
                    if (set_cnt_q == LAST_SET) state_d = S_DONE;
                    else set_cnt_d = set_cnt_q + SW'(1);
                end
            end
            S_FL_RD: begin
                if (!stall) begin
                    rd_en      = 1'b1;
                    rd_set     = set_cnt_q;
                    state_d    = S_FL_WR;
                    fl_first_d = 1'b1;
                end
            end
            S_FL_WR: begin
                flags_d = mask_cur;
                if (!stall) begin
                    wr_set       = set_cnt_q;
                    wr_rst_flush = mask_cur;
                    if (set_cnt_q == LAST_SET) state_d = S_DONE;
                    else begin
                        set_cnt_d = set_cnt_q + SW'(1);
                        state_d   = S_FL_RD;
                    end
                end
            end
            S_DONE: begin
                done_valid    = 1'b1;
                done_is_flush = kind_q;
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Requests arriving mid-sweep: flush coalesces into the pending bit, reset restarts the sweep.
        if (state_q != S_IDLE) begin
            if (flush_req) flush_pend_d = 1'b1;
            if (rst_req) begin
                state_d   = S_RST_WR;
                set_cnt_d = '0;
                kind_d    = 1'b0;
                if (state_q == S_FL_RD || state_q == S_FL_WR) flush_pend_d = 1'b1;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            set_cnt_q    <= '0;
            kind_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            flags_q      <= '0;
            fl_first_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            kind_q       <= kind_d;
            flush_pend_q <= flush_pend_d;
            flags_q      <= flags_d;
            fl_first_q   <= fl_first_d;
        end
    end

`ifdef LLC_SEQ_FLUSH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pop;
    logic [32:0] sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LLC_WAYS; i++) pop = pop + 32'(wr_rst_flush[i]);
        sum   = {1'b0, cnt_q} + {1'b0, pop};
        cnt_d = cnt_q;
        if (state_q == S_FL_WR && !stall) cnt_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign flush_line_cnt = cnt_q;
`else
    assign flush_line_cnt = '0;
`endif
endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Directed bench for llc_rst_flush_seq with LLC_SETS=4, LLC_WAYS=4.
module tb_llc_rst_flush_seq;
    logic       clk = 1'b0;
    logic       rst, rst_req, flush_req, stall, done_ready;
    logic [3:0] flush_flags;
    logic       busy, rd_en, wr_en_evict_way, done_valid, done_is_flush;
    logic [1:0] rd_set, wr_set;
    logic [3:0] wr_rst_flush;
    logic [31:0] flush_line_cnt;
    int checks = 0;
    int failures = 0;

`ifdef LLC_SEQ_FLUSH_CNT_EN
    localparam logic [31:0] CNT_A = 32'd7;
    localparam logic [31:0] CNT_B = 32'd15;
`else
    localparam logic [31:0] CNT_A = 32'd0;
    localparam logic [31:0] CNT_B = 32'd0;
`endif

    llc_rst_flush_seq #(.LLC_SETS(4), .LLC_WAYS(4)) dut (
        .clk(clk), .rst(rst), .rst_req(rst_req), .flush_req(flush_req), .stall(stall),
        .flush_flags(flush_flags), .busy(busy), .rd_en(rd_en), .rd_set(rd_set), .wr_set(wr_set),
        .wr_rst_flush(wr_rst_flush), .wr_en_evict_way(wr_en_evict_way), .done_valid(done_valid),
        .done_is_flush(done_is_flush), .done_ready(done_ready), .flush_line_cnt(flush_line_cnt)
    );

    always #5 clk = ~clk;

    // Packed view: {busy, rd_en, rd_set, wr_set, wr_rst_flush, evict, done_valid, done_is_flush}
    function automatic logic [12:0] outs();
        return {busy, rd_en, rd_set, wr_set, wr_rst_flush, wr_en_evict_way, done_valid, done_is_flush};
    endfunction

    function automatic logic [12:0] ev(input logic b, input logic r, input logic [1:0] rs,
                                       input logic [1:0] ws, input logic [3:0] m,
                                       input logic e, input logic dv, input logic df);
        return {b, r, rs, ws, m, e, dv, df};
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_req = 1'b0; flush_req = 1'b0; stall = 1'b0; done_ready = 1'b0; flush_flags = '0;
        adv(); adv();
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL reset_outs got %h want %h", outs(), 13'd0); end
        checks++;
        if (flush_line_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", flush_line_cnt); end
        rst = 1'b0;
        adv();
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL post_reset_idle got %h want %h", outs(), 13'd0); end
    endtask

    task automatic test_reset_sweep();
        rst_req = 1'b1;
        adv();
        rst_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 0, 0, 2'(i), 4'hF, 1, 0, 0)) begin
                failures++; $display("FAIL rst_sweep_wr%0d got %h want %h", i, outs(), ev(1, 0, 0, 2'(i), 4'hF, 1, 0, 0));
            end
            adv();
        end
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 0)) begin failures++; $display("FAIL rst_sweep_done got %h want %h", outs(), ev(1, 0, 0, 0, 0, 0, 1, 0)); end
        done_ready = 1'b1;
        adv();
        done_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL rst_sweep_idle got %h want %h", outs(), 13'd0); end
        adv();
    endtask

    task automatic test_flush();
        logic [3:0] fl [4];
        fl[0] = 4'b0101; fl[1] = 4'b0000; fl[2] = 4'hF; fl[3] = 4'b1000;
        flush_req = 1'b1;
        adv();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush_flags = 4'hA;
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 1, 2'(i), 0, 0, 0, 0, 0)) begin failures++; $display("FAIL flush_rd%0d got %h want %h", i, outs(), ev(1, 1, 2'(i), 0, 0, 0, 0, 0)); end
            adv();
            flush_flags = fl[i];
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 0, 0, 2'(i), fl[i], 0, 0, 0)) begin failures++; $display("FAIL flush_wr%0d got %h want %h", i, outs(), ev(1, 0, 0, 2'(i), fl[i], 0, 0, 0)); end
            adv();
        end
        flush_flags = '0;
        done_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 1)) begin failures++; $display("FAIL flush_done got %h want %h", outs(), ev(1, 0, 0, 0, 0, 0, 1, 1)); end
        adv();
        done_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_line_cnt !== CNT_A) begin failures++; $display("FAIL flush_cnt got %0d want %0d", flush_line_cnt, CNT_A); end
        adv();
    endtask

    task automatic test_stall();
        logic [3:0] fl [4];
        fl[0] = 4'b0011; fl[1] = 4'b0110; fl[2] = 4'b0011; fl[3] = 4'b0011;
        flush_req = 1'b1;
        adv();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush_flags = '0;
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 1, 2'(i), 0, 0, 0, 0, 0)) begin failures++; $display("FAIL stall_rd%0d got %h want %h", i, outs(), ev(1, 1, 2'(i), 0, 0, 0, 0, 0)); end
            adv();
            flush_flags = fl[i];
            if (i == 1) begin
                for (int s = 0; s < 3; s++) begin
                    stall = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (outs() !== ev(1, 0, 0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL stall_hold%0d got %h want %h", s, outs(), ev(1, 0, 0, 0, 0, 0, 0, 0)); end
                    adv();
                    flush_flags = 4'b1001;
                end
                stall = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 0, 0, 2'(i), fl[i], 0, 0, 0)) begin failures++; $display("FAIL stall_wr%0d got %h want %h", i, outs(), ev(1, 0, 0, 2'(i), fl[i], 0, 0, 0)); end
            adv();
        end
        flush_flags = '0;
        done_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 1)) begin failures++; $display("FAIL stall_done got %h want %h", outs(), ev(1, 0, 0, 0, 0, 0, 1, 1)); end
        adv();
        done_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_line_cnt !== CNT_B) begin failures++; $display("FAIL stall_cnt got %0d want %0d", flush_line_cnt, CNT_B); end
        adv();
    endtask

    // Reset sweep then DONE accepted; the pending flush must then start on its own.
    task automatic rst_then_pending_flush(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 0, 0, 2'(i), 4'hF, 1, 0, 0)) begin failures++; $display("FAIL %s_rst%0d got %h want %h", tag, i, outs(), ev(1, 0, 0, 2'(i), 4'hF, 1, 0, 0)); end
            adv();
        end
        done_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 0)) begin failures++; $display("FAIL %s_rst_done got %h want %h", tag, outs(), ev(1, 0, 0, 0, 0, 0, 1, 0)); end
        adv();
        done_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL %s_idle got %h want %h", tag, outs(), 13'd0); end
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 1, 2'(i), 0, 0, 0, 0, 0)) begin failures++; $display("FAIL %s_flrd%0d got %h want %h", tag, i, outs(), ev(1, 1, 2'(i), 0, 0, 0, 0, 0)); end
            adv();
            adv();
        end
        done_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 1)) begin failures++; $display("FAIL %s_fl_done got %h want %h", tag, outs(), ev(1, 0, 0, 0, 0, 0, 1, 1)); end
        adv();
        done_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL %s_end_idle got %h want %h", tag, outs(), 13'd0); end
        adv();
    endtask

    task automatic test_simultaneous();
        flush_flags = '0;
        rst_req = 1'b1; flush_req = 1'b1;
        adv();
        rst_req = 1'b0; flush_req = 1'b0;
        rst_then_pending_flush("simul");
    endtask

    task automatic test_abort();
        flush_flags = '0;
        flush_req = 1'b1;
        adv();
        flush_req = 1'b0;
        repeat (4) adv();
        rst_req = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== ev(1, 1, 2, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL abort_rd2 got %h want %h", outs(), ev(1, 1, 2, 0, 0, 0, 0, 0)); end
        adv();
        rst_req = 1'b0;
        rst_then_pending_flush("abort");
        @(negedge clk);
        checks++;
        if (flush_line_cnt !== CNT_B) begin failures++; $display("FAIL abort_cnt got %0d want %0d", flush_line_cnt, CNT_B); end
    endtask

    task automatic test_back_pressure();
        rst_req = 1'b1;
        adv();
        rst_req = 1'b0;
        repeat (4) adv();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== ev(1, 0, 0, 0, 0, 0, 1, 0)) begin failures++; $display("FAIL bp_hold%0d got %h want %h", i, outs(), ev(1, 0, 0, 0, 0, 0, 1, 0)); end
            adv();
        end
        rst = 1'b1;
        adv();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL bp_rst_outs got %h want %h", outs(), 13'd0); end
        checks++;
        if (flush_line_cnt !== 32'd0) begin failures++; $display("FAIL bp_rst_cnt got %0d want 0", flush_line_cnt); end
        adv();
        @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin failures++; $display("FAIL bp_stays_idle got %h want %h", outs(), 13'd0); end
    endtask

    initial begin
        test_reset();
        test_reset_sweep();
        test_flush();
        test_stall();
        test_simultaneous();
        test_abort();
        test_back_pressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
